// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding and EJTAG IR opcodes shared by the TAP, DR mux and DR blocks.
package jtag_pkg;

   // Standard 1149.1 state encoding
   typedef enum logic [3:0] {
      TAP_EXIT2_DR   = 4'h0,
      TAP_EXIT1_DR   = 4'h1,
      TAP_SHIFT_DR   = 4'h2,
      TAP_PAUSE_DR   = 4'h3,
      TAP_SELECT_IR  = 4'h4,
      TAP_UPDATE_DR  = 4'h5,
      TAP_CAPTURE_DR = 4'h6,
      TAP_SELECT_DR  = 4'h7,
      TAP_EXIT2_IR   = 4'h8,
      TAP_EXIT1_IR   = 4'h9,
      TAP_SHIFT_IR   = 4'hA,
      TAP_PAUSE_IR   = 4'hB,
      TAP_RUN_IDLE   = 4'hC,
      TAP_UPDATE_IR  = 4'hD,
      TAP_CAPTURE_IR = 4'hE,
      TAP_TLR        = 4'hF
   } tap_state_t;

   localparam logic [3:0] IR_IDCODE         = 4'b0000;
   localparam logic [3:0] IR_IMPCODE        = 4'b0001;
   localparam logic [3:0] IR_ADDRESS        = 4'b0010;
   localparam logic [3:0] IR_DATA           = 4'b0011;
   localparam logic [3:0] IR_CONTROL        = 4'b0100;
   localparam logic [3:0] IR_EJTAGBOOT      = 4'b0101;
   localparam logic [3:0] IR_SAMPLE_PRELOAD = 4'b0110;
   localparam logic [3:0] IR_BYPASS         = 4'b0111;

   // Opcodes routed to the 1-bit bypass path (explicit BYPASS plus all unused upper codes)
   function automatic logic is_bypass_op(input logic [3:0] op);
      return (op == IR_BYPASS) || op[3];
   endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - TAP pins and DR select/strobe network; master = TAP controller.
interface jtag_tap_ctrl_if #(
   parameter int IR_W = 4
);
   logic            tms;
   logic            tdi;
   logic            s_data_in;
   logic            tdo;
   logic            tdo_oe;
   logic [IR_W-1:0] sel;
   logic            shift_dr;
   logic            clk_dr;
   logic            update_dr;
   logic            tlr;

   modport master (
      input  tms, tdi, s_data_in,
      output tdo, tdo_oe, sel, shift_dr, clk_dr, update_dr, tlr
   );

   modport slave (
      output tms, tdi, s_data_in,
      input  tdo, tdo_oe, sel, shift_dr, clk_dr, update_dr, tlr
   );
endinterface

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP state machine with Moore decodes of the registered state.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tms,
   output tap_state_t o_state,
   output logic       o_shift_dr,
   output logic       o_clk_dr,
   output logic       o_update_dr,
   output logic       o_tlr,
   output logic       o_tdo_oe
);
   tap_state_t r_state;
   tap_state_t w_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= TAP_TLR;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_shift_dr  = 1'b0;
      o_clk_dr    = 1'b0;
      o_update_dr = 1'b0;
      o_tlr       = 1'b0;
      o_tdo_oe    = 1'b0;
      unique case (r_state)
         TAP_TLR:        w_next = i_tms ? TAP_TLR       : TAP_RUN_IDLE;
         TAP_RUN_IDLE:   w_next = i_tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
         TAP_SELECT_DR:  w_next = i_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
         TAP_CAPTURE_DR: w_next = i_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   w_next = i_tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   w_next = i_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   w_next = i_tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   w_next = i_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  w_next = i_tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
         TAP_SELECT_IR:  w_next = i_tms ? TAP_TLR       : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: w_next = i_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   w_next = i_tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   w_next = i_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   w_next = i_tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   w_next = i_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         TAP_UPDATE_IR:  w_next = i_tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
         default:        w_next = TAP_TLR;
      endcase
      o_shift_dr  = (r_state == TAP_SHIFT_DR);
      o_clk_dr    = (r_state == TAP_SHIFT_DR) || (r_state == TAP_CAPTURE_DR);
      o_update_dr = (r_state == TAP_UPDATE_DR);
      o_tlr       = (r_state == TAP_TLR);
      o_tdo_oe    = (r_state == TAP_SHIFT_DR) || (r_state == TAP_SHIFT_IR);
   end

   assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - EJTAG TAP controller top: FSM, IR, tdo mux.
// Optional internal bypass flop and DR strobe gating: JTAG_TAP_INT_BYPASS_EN.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int              IR_W       = 4,
   parameter logic [IR_W-1:0] IR_RESET   = IR_W'(0),
   parameter logic [IR_W-1:0] IR_CAPTURE = IR_W'(1)
)(
   input  logic                   clk,
   input  logic                   rst,
   jtag_tap_ctrl_if.master        tap
);
   tap_state_t      w_state;
   logic            w_shift_dr;
   logic            w_clk_dr;
   logic            w_update_dr;
   logic            w_tlr;
   logic            w_tdo_oe;
   logic            w_dr_bit;
   logic            w_gate;
   logic            w_tdo;
   logic [IR_W-1:0] r_ir;
   logic [IR_W-1:0] r_ir_shift;

   jtag_tap_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_tms       (tap.tms),
      .o_state     (w_state),
      .o_shift_dr  (w_shift_dr),
      .o_clk_dr    (w_clk_dr),
      .o_update_dr (w_update_dr),
      .o_tlr       (w_tlr),
      .o_tdo_oe    (w_tdo_oe)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ir       <= IR_RESET;
         r_ir_shift <= IR_CAPTURE;
      end else begin
         case (w_state)
            TAP_TLR:        r_ir       <= IR_RESET;
            TAP_CAPTURE_IR: r_ir_shift <= IR_CAPTURE;
            TAP_SHIFT_IR:   r_ir_shift <= {tap.tdi, r_ir_shift[IR_W-1:1]};
            TAP_UPDATE_IR:  r_ir       <= r_ir_shift;
            default: ;
         endcase
      end
   end

`ifdef JTAG_TAP_INT_BYPASS_EN
   logic r_byp;
   logic w_byp_sel;

   assign w_byp_sel = is_bypass_op(r_ir[3:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byp <= 1'b0;
      end else if (w_byp_sel) begin
         if (w_state == TAP_CAPTURE_DR)    r_byp <= 1'b0;
         else if (w_state == TAP_SHIFT_DR) r_byp <= tap.tdi;
      end
   end

   assign w_dr_bit = w_byp_sel ? r_byp : tap.s_data_in;
   assign w_gate   = w_byp_sel;
`else
   assign w_dr_bit = tap.s_data_in;
   assign w_gate   = 1'b0;
`endif

   // Combinational from flops; the pad stage retimes tdo to the falling edge
   always_comb begin
      w_tdo = 1'b0;
      if (w_state == TAP_SHIFT_IR)      w_tdo = r_ir_shift[0];
      else if (w_state == TAP_SHIFT_DR) w_tdo = w_dr_bit;
   end

   assign tap.tdo       = w_tdo;
   assign tap.tdo_oe    = w_tdo_oe;
   assign tap.sel       = r_ir;
   assign tap.shift_dr  = w_shift_dr  & ~w_gate;
   assign tap.clk_dr    = w_clk_dr    & ~w_gate;
   assign tap.update_dr = w_update_dr & ~w_gate;
   assign tap.tlr       = w_tlr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - scoreboard bench for jtag_tap_ctrl against a table-driven TAP model.
module tb_jtag_tap_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtag_tap_ctrl_if #(.IR_W(4)) u_if ();

   jtag_tap_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .tap (u_if)
   );

   typedef struct packed {
      logic       tdo;
      logic       tdo_oe;
      logic [3:0] sel;
      logic       shift_dr;
      logic       clk_dr;
      logic       update_dr;
      logic       tlr;
   } exp_t;

   localparam int M_TLR = 0,  M_RTI = 1,  M_SDR = 2,  M_CDR = 3,
                  M_SHDR = 4, M_E1DR = 5, M_PDR = 6,  M_E2DR = 7,
                  M_UDR = 8,  M_SIR = 9,  M_CIR = 10, M_SHIR = 11,
                  M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   t0[16];
   int   t1[16];
   int   m_st, m_ir, m_irs, m_byp;
   bit   m_sdi;
   bit   counting = 0;
   int   cnt_clk, cnt_sh, cnt_up;

   function automatic bit m_is_byp();
`ifdef JTAG_TAP_INT_BYPASS_EN
      return (m_ir == 7) || (m_ir >= 8);
`else
      return 1'b0;
`endif
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      bit   byp;
      byp         = m_is_byp();
      e.sel       = 4'(m_ir);
      e.tlr       = (m_st == M_TLR);
      e.tdo_oe    = (m_st == M_SHDR) || (m_st == M_SHIR);
      e.shift_dr  = (m_st == M_SHDR) && !byp;
      e.clk_dr    = ((m_st == M_SHDR) || (m_st == M_CDR)) && !byp;
      e.update_dr = (m_st == M_UDR) && !byp;
      if (m_st == M_SHIR)      e.tdo = m_irs[0];
      else if (m_st == M_SHDR) e.tdo = byp ? m_byp[0] : m_sdi;
      else                     e.tdo = 1'b0;
      return e;
   endfunction

   task automatic m_step(input bit tms, input bit tdi);
      bit byp;
      byp = m_is_byp();
      case (m_st)
         M_TLR:  m_ir  = 0;
         M_CIR:  m_irs = 1;
         M_SHIR: m_irs = (m_irs >> 1) | (int'(tdi) << 3);
         M_UIR:  m_ir  = m_irs;
         M_CDR:  if (byp) m_byp = 0;
         M_SHDR: if (byp) m_byp = int'(tdi);
         default: ;
      endcase
      m_st = tms ? t1[m_st] : t0[m_st];
   endtask

   task automatic tick(input bit tms, input bit tdi, input bit sdi);
      @(negedge clk);
      if (counting) begin
         cnt_clk += int'(u_if.clk_dr);
         cnt_sh  += int'(u_if.shift_dr);
         cnt_up  += int'(u_if.update_dr);
      end
      #1;
      rst             = 1'b0;
      u_if.tms        = tms;
      u_if.tdi        = tdi;
      u_if.s_data_in  = sdi;
      m_sdi           = sdi;
      m_step(tms, tdi);
      q.push_back(m_expect());
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      #1;
      rst   = 1'b1;
      m_st  = M_TLR;
      m_ir  = 0;
      m_irs = 1;
      m_byp = 0;
      q.push_back(m_expect());
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // From RTI: shift v LSB first into IR and return to RTI
   task automatic load_ir(input logic [3:0] v);
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      for (int i = 0; i < 4; i++) tick(i == 3, v[i], 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (q.size() != 0) begin
         e = q.pop_front();
         g.tdo       = u_if.tdo;
         g.tdo_oe    = u_if.tdo_oe;
         g.sel       = u_if.sel;
         g.shift_dr  = u_if.shift_dr;
         g.clk_dr    = u_if.clk_dr;
         g.update_dr = u_if.update_dr;
         g.tlr       = u_if.tlr;
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL outputs @%0t: got tdo=%b oe=%b sel=%b sh=%b cdr=%b upd=%b tlr=%b expected tdo=%b oe=%b sel=%b sh=%b cdr=%b upd=%b tlr=%b",
                     $time, g.tdo, g.tdo_oe, g.sel, g.shift_dr, g.clk_dr, g.update_dr, g.tlr,
                     e.tdo, e.tdo_oe, e.sel, e.shift_dr, e.clk_dr, e.update_dr, e.tlr);
         end
      end
   end

   initial begin
      t0 = '{M_RTI, M_RTI, M_CDR, M_SHDR, M_SHDR, M_PDR, M_PDR, M_SHDR,
             M_RTI, M_CIR, M_SHIR, M_SHIR, M_PIR, M_PIR, M_SHIR, M_RTI};
      t1 = '{M_TLR, M_SDR, M_SIR, M_E1DR, M_E1DR, M_UDR, M_E2DR, M_UDR,
             M_SDR, M_TLR, M_E1IR, M_E1IR, M_UIR, M_E2IR, M_UIR, M_SDR};
      u_if.tms       = 1'b1;
      u_if.tdi       = 1'b0;
      u_if.s_data_in = 1'b0;

      // Reset state, then tms=1 x5 stays in TLR
      rst_pulse();
      repeat (5) tick(1, 0, 0);

      // Mid-SHIFT_DR escape with five tms=1
      tick(0, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 1, 1);
      tick(0, 0, 1);
      repeat (5) tick(1, 0, 0);
      @(negedge clk);
      check_val("tlr_after_5", int'(u_if.tlr), 1);
      check_val("sel_after_5", int'(u_if.sel), 0);

      // IR load 1,1,1,0 -> 0111
      tick(0, 0, 0);
      load_ir(4'b0111);
      @(negedge clk);
      check_val("sel_bypass_load", int'(u_if.sel), 7);

      // DR scan with sel=0011 and strobe counting
      load_ir(4'b0011);
      cnt_clk = 0; cnt_sh = 0; cnt_up = 0;
      counting = 1;
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 1);
      for (int i = 0; i < 7; i++) tick(0, 1'($urandom), 1'($urandom));
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      counting = 0;
      check_val("clk_dr_cycles", cnt_clk, 9);
      check_val("shift_dr_cycles", cnt_sh, 8);
      check_val("update_dr_cycles", cnt_up, 1);

      // Pause path: 1,0 | pause x3 | 1,0
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
      tick(0, 1, 0);
      tick(1, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(1, 1, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      @(negedge clk);
      check_val("sel_pause_path", int'(u_if.sel), 5);

      // Bypass opcode DR shift 1,0,1
      load_ir(4'b0111);
      tick(1, 0, 1);
      tick(0, 0, 1);
      tick(0, 0, 1);
      tick(0, 1, 1);
      tick(0, 0, 0);
      tick(1, 1, 1);
      tick(1, 0, 0);
      tick(0, 0, 0);

      // Reset in the middle of an IR shift
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      rst_pulse();
      tick(0, 0, 0);

      // Randomized traffic with occasional async reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) rst_pulse();
         else tick($urandom_range(0, 99) < 35, 1'($urandom), 1'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      check_val("scoreboard_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
